// File: rtl/imu_sample_sequencer.sv
// imu_sample_sequencer: DEPTH-entry sample FIFO in front of the madgwick filter core.
// Issues one IMU sample at a time and holds each quaternion result with a sequence tag.
module imu_sample_sequencer #(
    parameter int ACC_WIDTH  = 11,
    parameter int GYRO_WIDTH = 14,
    parameter int Q_WIDTH    = 16,
    parameter int DEPTH      = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mode_drop,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ACC_WIDTH-1:0]      in_a_x,
    input  logic [ACC_WIDTH-1:0]      in_a_y,
    input  logic [ACC_WIDTH-1:0]      in_a_z,
    input  logic [GYRO_WIDTH-1:0]     in_w_x,
    input  logic [GYRO_WIDTH-1:0]     in_w_y,
    input  logic [GYRO_WIDTH-1:0]     in_w_z,
    output logic                      flt_valid_in,
    input  logic                      flt_ready_in,
    output logic [ACC_WIDTH-1:0]      flt_a_x,
    output logic [ACC_WIDTH-1:0]      flt_a_y,
    output logic [ACC_WIDTH-1:0]      flt_a_z,
    output logic [GYRO_WIDTH-1:0]     flt_w_x,
    output logic [GYRO_WIDTH-1:0]     flt_w_y,
    output logic [GYRO_WIDTH-1:0]     flt_w_z,
    input  logic                      flt_valid_out,
    output logic                      flt_ready_out,
    input  logic [Q_WIDTH-1:0]        flt_q_w,
    input  logic [Q_WIDTH-1:0]        flt_q_x,
    input  logic [Q_WIDTH-1:0]        flt_q_y,
    input  logic [Q_WIDTH-1:0]        flt_q_z,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [Q_WIDTH-1:0]        out_q_w,
    output logic [Q_WIDTH-1:0]        out_q_x,
    output logic [Q_WIDTH-1:0]        out_q_y,
    output logic [Q_WIDTH-1:0]        out_q_z,
    output logic [CNT_WIDTH-1:0]      out_seq,
    output logic [$clog2(DEPTH):0]    level,
    output logic [CNT_WIDTH-1:0]      overflow_cnt
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int ENTRY_W = 3 * ACC_WIDTH + 3 * GYRO_WIDTH;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    state_t               state_q;
    logic [ENTRY_W-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]     level_q, level_d;
    logic [CNT_WIDTH-1:0] ovf_q, seq_q;
    logic                 flt_valid_in_q, flt_ready_out_q, out_valid_q;
    logic [Q_WIDTH-1:0]   q_w_q, q_x_q, q_y_q, q_z_q;

    logic                 full, push, pop, drop;
    logic [ENTRY_W-1:0]   wr_entry, head;

    assign full     = (level_q == FULL_LVL);
    assign in_ready = mode_drop | ~full;
    assign pop      = flt_valid_in_q & flt_ready_in;
    // A full FIFO still accepts in drop mode when the head leaves in the same cycle.
    assign push     = in_valid & in_ready & (~full | pop);
    assign drop     = in_valid & mode_drop & full & ~pop;

    assign wr_entry = {in_a_x, in_a_y, in_a_z, in_w_x, in_w_y, in_w_z};
    assign head     = mem_q[rd_ptr_q];
    assign {flt_a_x, flt_a_y, flt_a_z, flt_w_x, flt_w_y, flt_w_z} = head;

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
            if (drop && (ovf_q != '1)) ovf_q <= ovf_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            flt_valid_in_q  <= 1'b0;
            flt_ready_out_q <= 1'b0;
            out_valid_q     <= 1'b0;
            q_w_q           <= '0;
            q_x_q           <= '0;
            q_y_q           <= '0;
            q_z_q           <= '0;
            seq_q           <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (level_q != '0) begin
                        state_q        <= ISSUE;
                        flt_valid_in_q <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (flt_ready_in) begin
                        state_q         <= WAIT;
                        flt_valid_in_q  <= 1'b0;
                        flt_ready_out_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (flt_valid_out) begin
                        state_q         <= HOLD;
                        flt_ready_out_q <= 1'b0;
                        out_valid_q     <= 1'b1;
                        q_w_q           <= flt_q_w;
                        q_x_q           <= flt_q_x;
                        q_y_q           <= flt_q_y;
                        q_z_q           <= flt_q_z;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        seq_q       <= seq_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign flt_valid_in  = flt_valid_in_q;
    assign flt_ready_out = flt_ready_out_q;
    assign out_valid     = out_valid_q;
    assign out_q_w       = q_w_q;
    assign out_q_x       = q_x_q;
    assign out_q_y       = q_y_q;
    assign out_q_z       = q_z_q;
    assign out_seq       = seq_q;
    assign level         = level_q;
    assign overflow_cnt  = ovf_q;
endmodule
